sram_burst_reader: RTL and testbench

//  Burst read engine for port 1 (read-only) of the 1rw1r SRAM wrapper. It accepts a command
//  (base address, length), then issues one read per cycle on the wrapper's port-1 controls.
//  It absorbs the one-cycle SRAM read latency and returns the words on a valid/ready stream

---
 rtl/sram_burst_reader.sv | 146 ++++++++++++++
 tb/tb_sram_burst_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_reader.sv
// Burst read engine for port 1 (read-only) of the 1rw1r SRAM wrapper.
// Issues one read per cycle. Absorbs the one-cycle read latency through a small output FIFO.
// Streams the words out on a valid/ready interface with full backpressure.
module sram_burst_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 9,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_csb1,
  output logic [ADDR_WIDTH-1:0] mem_addr1,
  input  logic [DATA_WIDTH-1:0] mem_dout1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic                  rd_pend_q;
  logic                  rd_last_q;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic                  issue, issue_last, push, pop;
  logic [ADDR_WIDTH-1:0] issue_addr;

  // Datapath decode: current issue address, last-beat tag and FIFO handshakes.
  always_comb begin
    issue_addr = base_q + issued_q[ADDR_WIDTH-1:0];
    issue_last = (issued_q == len_q - LEN_WIDTH'(1));
    push       = rd_pend_q;
    out_valid  = (count_q != '0);
    pop        = out_valid & out_ready;
  end

  // Next-state logic; issue is throttled so the FIFO can always absorb in-flight data.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            base_d   = base_addr;
            len_d    = len;
            issued_d = '0;
            state_d  = StIssue;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (count_q + CntW'(rd_pend_q) < CntW'(FIFO_DEPTH)) begin
          issue    = 1'b1;
          issued_d = issued_q + LEN_WIDTH'(1);
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, pending-read tracking and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      done_q      <= 1'b0;
      addr_hold_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      done_q    <= done_d;
      rd_pend_q <= issue;
      rd_last_q <= issue & issue_last;
      if (issue) addr_hold_q <= issue_addr;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; a read landing during reset is dropped.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_data[wr_ptr_q] <= mem_dout1;
      fifo_last[wr_ptr_q] <= rd_last_q;
    end
  end

  // Outputs; the address holds the last issued value while no read is requested.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    mem_csb1  = issue;
    mem_addr1 = issue ? issue_addr : addr_hold_q;
    out_data  = fifo_data[rd_ptr_q];
    out_last  = out_valid & fifo_last[rd_ptr_q];
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with an SRAM model and a beat scoreboard.
module tb_sram_burst_reader;

  logic        clk, rst, start;
  logic [7:0]  base_addr;
  logic [8:0]  len;
  logic        busy, done, mem_csb1;
  logic [7:0]  mem_addr1;
  logic [31:0] mem_dout1;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;

  logic [31:0] mem [256];
  logic [32:0] sb [$];
  logic [7:0]  rd_log [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          last_cnt = 0;

  sram_burst_reader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .LEN_WIDTH (9),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .mem_csb1 (mem_csb1),
    .mem_addr1(mem_addr1),
    .mem_dout1(mem_dout1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency read port; returns junk when not read to expose mistimed captures.
  always @(posedge clk) begin
    if (mem_csb1) mem_dout1 <= mem[mem_addr1];
    else          mem_dout1 <= $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor away from the active edge: log reads, count pulses, score accepted beats.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      if (done) done_cnt++;
      if (mem_csb1) rd_log.push_back(mem_addr1);
      if (out_valid && out_ready) begin
        if (out_last) last_cnt++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL beat_unexpected: observed data %h with empty queue, expected no beat",
                 out_data);
        end else begin
          e = sb.pop_front();
          chk("beat_data", out_data, e[31:0]);
          chk("beat_last", {31'd0, out_last}, {31'd0, e[32]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] b, input logic [8:0] l);
    for (int i = 0; i < int'(l); i++) sb.push_back({(i == int'(l) - 1), mem[8'(int'(b) + i)]});
    start     = 1'b1;
    base_addr = b;
    len       = l;
    tick();
    start     = 1'b0;
    base_addr = $urandom;
    len       = $urandom;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, l0;
    logic [31:0] held;
    for (int i = 0; i < 256; i++) mem[i] = {i[7:0], 24'($urandom)};
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_csb", {31'd0, mem_csb1}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr1}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: exact cycle timing of a 4-word burst with continuous ready
    out_ready = 1'b1;
    start_burst(8'h10, 9'd4);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("t1_csb_c%0d", c), {31'd0, mem_csb1}, 32'(c <= 4));
      if (c <= 4) chk($sformatf("t1_addr_c%0d", c), {24'd0, mem_addr1}, 32'(8'h10 + c - 1));
      chk($sformatf("t1_valid_c%0d", c), {31'd0, out_valid}, 32'(c >= 3 && c <= 6));
      chk($sformatf("t1_last_c%0d", c), {31'd0, out_last}, 32'(c == 6));
      chk($sformatf("t1_done_c%0d", c), {31'd0, done}, 32'(c == 7));
      chk($sformatf("t1_busy_c%0d", c), {31'd0, busy}, 32'(c <= 6));
      tick();
    end
    chk("t1_sb_empty", sb.size(), 32'd0);

    // 2: address wrap-around
    rd_log.delete();
    start_burst(8'hFE, 9'd4);
    wait_done("t2_done", 50);
    chk("t2_nreads", rd_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++)
      chk($sformatf("t2_addr%0d", i), {24'd0, rd_log[i]}, {24'd0, 8'(8'hFE + i)});
    chk("t2_sb_empty", sb.size(), 32'd0);
    tick();

    // 3: full backpressure, then release
    rd_log.delete();
    out_ready = 1'b0;
    start_burst(8'h40, 9'd8);
    for (int i = 0; i < 10; i++) tick();
    chk("t3_nreads", rd_log.size(), 32'd4);
    chk("t3_csb_off", {31'd0, mem_csb1}, 32'd0);
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_head", out_data, mem[8'h40]);
    held = out_data;
    tick(); tick(); tick();
    chk("t3_stable", out_data, held);
    chk("t3_stable_head", out_data, mem[8'h40]);
    out_ready = 1'b1;
    wait_done("t3_done", 60);
    chk("t3_total_reads", rd_log.size(), 32'd8);
    chk("t3_sb_empty", sb.size(), 32'd0);
    tick();

    // 4: zero-length command, then start while busy
    rd_log.delete();
    d0 = done_cnt;
    start_burst(8'h55, 9'd0);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t4_done_pulse", {31'd0, done}, 32'd0);
    chk("t4_no_reads", rd_log.size(), 32'd0);
    start_burst(8'h20, 9'd3);
    chk("t4_busy2", {31'd0, busy}, 32'd1);
    start = 1'b1; base_addr = 8'h80; len = 9'd5;
    tick(); tick();
    start = 1'b0;
    wait_done("t4_done2", 50);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_ignored_reads", rd_log.size(), 32'd3);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_done_cnt", 32'(done_cnt - d0), 32'd2);
    chk("t4_sb_empty", sb.size(), 32'd0);

    // 5: reset mid-burst after two beats
    start_burst(8'h30, 9'd6);
    tick(); tick(); tick(); tick();
    out_ready = 1'b0;
    rst = 1'b1;
    chk("t5_beats_before_rst", sb.size(), 32'd4);
    d0 = done_cnt;
    tick();
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_csb", {31'd0, mem_csb1}, 32'd0);
    chk("t5_addr", {24'd0, mem_addr1}, 32'd0);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_last", {31'd0, out_last}, 32'd0);
    sb.delete();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_empty_after", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    start_burst(8'h31, 9'd5);
    wait_done("t5_done_new", 50);
    chk("t5_sb_empty", sb.size(), 32'd0);
    tick();

    // 6: maximum-length burst with random backpressure
    d0 = done_cnt;
    l0 = last_cnt;
    start_burst(8'h9C, 9'd256);
    begin
      int n = 0;
      while (!done && n < 3000) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
    end
    chk("t6_done", {31'd0, done}, 32'd1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t6_sb_empty", sb.size(), 32'd0);
    chk("t6_single_last", 32'(last_cnt - l0), 32'd1);
    chk("t6_single_done", 32'(done_cnt - d0), 32'd1);
    chk("t6_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
